// File: rtl/parking_pkg.sv
// Shared types for the parking lot controller: FSM state encoding and
// occupancy width helper.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PIN,
    GATE_OPEN,
    CLOSING,
    BLOCKED
  } state_t;

  function automatic int occ_w(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/parking_lot_controller_if.sv
// Entry/exit sensor and gate bus. Ports: master drives vehicle_arrival,
// code, code_ack, vehicle_left, vehicle_exit; slave drives the gate status.
interface parking_lot_controller_if #(
  parameter int CODE_W = 16,
  parameter int OCC_W  = 4
);
  logic              vehicle_arrival;
  logic [CODE_W-1:0] code;
  logic              code_ack;
  logic              vehicle_left;
  logic              vehicle_exit;
  logic              open_gate;
  logic              close_gate;
  logic              wrong_pin;
  logic              blocked_gate;
  logic              lot_full;
  logic [OCC_W-1:0]  occupancy;
  logic [3:0]        attempts;

  modport master (
    output vehicle_arrival, code, code_ack,
    output vehicle_left, vehicle_exit,
    input  open_gate, close_gate, wrong_pin,
    input  blocked_gate, lot_full, occupancy, attempts
  );

  modport slave (
    input  vehicle_arrival, code, code_ack,
    input  vehicle_left, vehicle_exit,
    output open_gate, close_gate, wrong_pin,
    output blocked_gate, lot_full, occupancy, attempts
  );
endinterface

// File: rtl/occupancy_counter.sv
// Saturating lot occupancy counter with registered full flag.
// Ports: clk, rst (sync, high), inc, dec -> occupancy, lot_full.
module occupancy_counter #(
  parameter int CAPACITY = 8,
  parameter int OW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [OW-1:0] occupancy,
  output logic          lot_full
);
  logic [OW-1:0] occ_q, occ_d;
  logic          full_q, full_d;

  always_comb begin
    occ_d = occ_q;
    if (inc && !dec && occ_q != OW'(CAPACITY))
      occ_d = occ_q + 1'b1;
    else if (dec && !inc && occ_q != '0)
      occ_d = occ_q - 1'b1;
    full_d = (occ_d == OW'(CAPACITY));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= '0;
      full_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      full_q <= full_d;
    end
  end

  assign occupancy = occ_q;
  assign lot_full  = full_q;
endmodule

// File: rtl/parking_lot_controller.sv
// PIN-gated parking entry controller: FSM, gate timer, attempt counter.
// Ports: clk, rst (sync, high), bus (slave). Macro: ADMIN_UNLOCK_EN.
module parking_lot_controller
  import parking_pkg::*;
#(
  parameter int              CODE_W       = 16,
  parameter logic [CODE_W-1:0] CORRECT_CODE = 16'h2468,
  parameter logic [CODE_W-1:0] ADMIN_CODE   = 16'hA5A5,
  parameter int              MAX_ATTEMPTS = 3,
  parameter int              CAPACITY     = 8,
  parameter int              GATE_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  parking_lot_controller_if.slave bus
);
  localparam int OW = occ_w(CAPACITY);
  localparam int TW = $clog2(GATE_TIMEOUT);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    att_q, att_d;
  logic          wp_q, wp_d;
  logic          og_q, cg_q, bg_q;
  logic          inc;
  logic          lot_full;
  logic [OW-1:0] occupancy;

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    att_d   = att_q;
    wp_d    = 1'b0;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.vehicle_arrival && !lot_full) begin
          state_d = WAIT_PIN;
          att_d   = '0;
        end
      end
      WAIT_PIN: begin
        if (bus.code_ack) begin
          if (bus.code == CORRECT_CODE) begin
            state_d = GATE_OPEN;
            att_d   = '0;
          end else begin
            att_d = att_q + 1'b1;
            wp_d  = 1'b1;
            if (att_d == 4'(MAX_ATTEMPTS))
              state_d = BLOCKED;
          end
        end
      end
      GATE_OPEN: begin
        if (bus.vehicle_left) begin
          inc     = 1'b1;
          // a second car arriving as the first passes is a tailgate
          state_d = bus.vehicle_arrival ? BLOCKED : CLOSING;
        end else if (timer_q == TW'(GATE_TIMEOUT - 1)) begin
          state_d = CLOSING;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CLOSING: state_d = IDLE;
      BLOCKED: begin
`ifdef ADMIN_UNLOCK_EN
        if (bus.code_ack && bus.code == ADMIN_CODE) begin
          state_d = IDLE;
          att_d   = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      att_q   <= '0;
      wp_q    <= 1'b0;
      og_q    <= 1'b0;
      cg_q    <= 1'b0;
      bg_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      att_q   <= att_d;
      wp_q    <= wp_d;
      og_q    <= (state_d == GATE_OPEN);
      cg_q    <= (state_d == CLOSING);
      bg_q    <= (state_d == BLOCKED);
    end
  end

  occupancy_counter #(
    .CAPACITY (CAPACITY),
    .OW       (OW)
  ) u_occ (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc),
    .dec       (bus.vehicle_exit),
    .occupancy (occupancy),
    .lot_full  (lot_full)
  );

  assign bus.open_gate    = og_q;
  assign bus.close_gate   = cg_q;
  assign bus.wrong_pin    = wp_q;
  assign bus.blocked_gate = bg_q;
  assign bus.lot_full     = lot_full;
  assign bus.occupancy    = occupancy;
  assign bus.attempts     = att_q;
endmodule

// File: doc/parking_lot_controller.md
PARKING_LOT_CONTROLLER -- requirements
Module: parking_lot_controller

Interface
REQ-001 Parameter CODE_W, default 16: PIN width in bits.
REQ-002 Parameter CORRECT_CODE, default 16'h2468: entry PIN.
REQ-003 Parameter ADMIN_CODE, default 16'hA5A5: unlock PIN, used only under ADMIN_UNLOCK_EN.
REQ-004 Parameter MAX_ATTEMPTS, default 3, range 1..15: wrong PINs per arrival before block.
REQ-005 Parameter CAPACITY, default 8, minimum 1: lot spaces.
REQ-006 Parameter GATE_TIMEOUT, default 16, minimum 2: cycles the gate stays open without a passage.
REQ-007 Clock and reset: clk input 1, rising-edge clock; rst input 1, reset, synchronous, active-high.
REQ-008 Inputs: vehicle_arrival 1, car at entry; code CODE_W, PIN; code_ack 1, PIN valid this cycle; vehicle_left 1, car passed entry gate; vehicle_exit 1, car left lot by exit.
REQ-009 Outputs: open_gate 1; close_gate 1; wrong_pin 1; blocked_gate 1; lot_full 1; occupancy $clog2(CAPACITY+1); attempts 4.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, WAIT_PIN, GATE_OPEN, CLOSING and BLOCKED; all outputs SHALL be registered.
REQ-011 In IDLE, vehicle_arrival with lot_full=0 SHALL move to WAIT_PIN and clear attempts; with lot_full=1 arrival SHALL be ignored.
REQ-012 In WAIT_PIN, code_ack with code==CORRECT_CODE SHALL move to GATE_OPEN and clear attempts.
REQ-013 In WAIT_PIN, code_ack with a mismatch SHALL increment attempts and pulse wrong_pin for one cycle; if the new count equals MAX_ATTEMPTS, the FSM SHALL move to BLOCKED, otherwise it stays in WAIT_PIN.
REQ-014 Latency: every code_ack response SHALL appear at the first rising edge after the code_ack cycle; code_ack in any other state SHALL be ignored, except as in REQ-022.
REQ-015 In GATE_OPEN, open_gate=1 and a timer SHALL count from 0; vehicle_left alone SHALL move to CLOSING and increment occupancy.
REQ-016 vehicle_left and vehicle_arrival together in GATE_OPEN (tailgate) SHALL move to BLOCKED; occupancy +1.
REQ-017 When the timer reaches GATE_TIMEOUT-1 without vehicle_left, the FSM SHALL move to CLOSING with no occupancy change.
REQ-018 CLOSING SHALL last exactly one cycle with close_gate=1 and open_gate=0, then return to IDLE.
REQ-019 BLOCKED SHALL hold blocked_gate=1 and open_gate=0.
REQ-020 vehicle_exit SHALL decrement occupancy in any state, saturating at 0; increment saturates at CAPACITY; increment and decrement in the same cycle SHALL leave occupancy unchanged.
REQ-021 lot_full SHALL equal (occupancy==CAPACITY), updated in the same cycle as occupancy.

Configuration
REQ-022 With ADMIN_UNLOCK_EN defined, code_ack with code==ADMIN_CODE in BLOCKED SHALL move to IDLE and clear attempts; without it, BLOCKED SHALL exit only on rst, and ADMIN_CODE is unused.

Reset
REQ-023 On rst the FSM SHALL enter IDLE; occupancy, attempts, timer and all 1-bit outputs SHALL be 0; rst SHALL take priority over all inputs, including mid-passage in GATE_OPEN.

Structure
REQ-024 State encodings and the occupancy width function SHALL reside in shared package parking_pkg.
REQ-025 The occupancy counter with lot_full SHALL be a sub-module occupancy_counter; the FSM and timer stay in the top module.

Verification
REQ-026 rst; arrival; code 16'h2468 with ack; vehicle_left next cycle -> open_gate=1, then close_gate pulse, occupancy=1, IDLE.
REQ-027 Arrival; three acks with 16'h1111 -> wrong_pin pulses 3 times, attempts 1,2,3, blocked_gate=1 after third; further correct code ignored.
REQ-028 Correct code, no vehicle_left for 16 cycles -> close_gate at timeout, occupancy unchanged.
REQ-029 Fill 8 cars -> lot_full=1, next arrival ignored; vehicle_exit once -> occupancy=7, lot_full=0; simultaneous left+exit -> occupancy unchanged.
REQ-030 Gate open, vehicle_left and vehicle_arrival same cycle -> blocked_gate=1; with ADMIN_UNLOCK_EN, ack 16'hA5A5 -> IDLE.
REQ-031 rst asserted in GATE_OPEN -> next cycle all outputs 0, IDLE.
